// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-input word mux. It produces a registered one-hot
// grant and a mux select, and a hold counter bounds how long one requester keeps the bus.
module mux4_rr_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int n           = WORD_LENGTH,
  parameter int MAX_HOLD    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [n-1:0] in0,
  input  logic [n-1:0] in1,
  input  logic [n-1:0] in2,
  input  logic [n-1:0] in3,
  output logic [3:0]   grant,
  output logic [1:0]   sel,
  output logic         out_valid,
  output logic [n-1:0] out
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state, next_state;
  logic [1:0]        ptr, next_ptr;
  logic [HOLD_W-1:0] hold_cnt, next_hold;
  logic [3:0]        next_grant;
  logic [1:0]        next_sel;
  logic              next_valid;
  logic [3:0]        others;
  logic [1:0]        winner;
  logic              take_new;
  logic              go_idle;

  // Scan base+1, base+2, base+3, base: the last granted index comes last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign others = req & ~grant;
  assign winner = rr_pick(others, ptr);

  always_comb begin
    take_new = 1'b0;
    go_idle  = 1'b0;
    case (state)
      IDLE: take_new = |req;
      BUSY: begin
        if (!req[sel]) begin
          take_new = |others;
          go_idle  = ~(|others);
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (|others)) begin
          take_new = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_grant = grant;
    next_sel   = sel;
    next_valid = out_valid;
    next_hold  = hold_cnt;
    if (take_new) begin
      next_state = BUSY;
      next_ptr   = winner;
      next_sel   = winner;
      next_grant = 4'b0001 << winner;
      next_valid = 1'b1;
      next_hold  = HOLD_W'(1);
    end else if (go_idle) begin
      next_state = IDLE;
      next_grant = 4'b0000;
      next_valid = 1'b0;
      next_hold  = '0;
    end else if ((state == BUSY) && (hold_cnt < HOLD_MAX)) begin
      next_hold = hold_cnt + HOLD_W'(1);
    end
  end

  // ptr resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      hold_cnt  <= '0;
      grant     <= 4'b0000;
      sel       <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      hold_cnt  <= next_hold;
      grant     <= next_grant;
      sel       <= next_sel;
      out_valid <= next_valid;
    end
  end

  always_comb begin
    out = '0;
    if (out_valid) begin
      case (sel)
        2'd0:    out = in0;
        2'd1:    out = in1;
        2'd2:    out = in2;
        default: out = in3;
      endcase
    end
  end

endmodule
